// File: rtl/vga_pkg.sv
// Shared VGA pixel-path definitions: default active-area geometry, the
// frame reader FSM state type and the RGB565 -> RGB888 expansion.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } rd_state_e;

  // Each channel's top bits are replicated into the vacated low bits, so
  // full-scale 5/6-bit values map to 8'hFF and zero stays zero.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock pixel FIFO between the SRAM read pipeline and the VGA pop side.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   flush_i      synchronous empty; dominates write and read in that cycle
//   wr_en_i      push wr_data_i (ignored when full)
//   rd_en_i      pop (ignored when empty); rd_data_o shows the head entry
//   count_o      current occupancy, 0..DEPTH
//   empty_o      occupancy is zero
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [AW:0]   count_o,
  output logic          empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign do_wr = wr_en_i && !flush_i && (cnt_q != FULL_CNT);
  assign do_rd = rd_en_i && !flush_i && (cnt_q != '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_wr) wptr_d = wptr_q + AW'(1);
      if (do_rd) rptr_d = rptr_q + AW'(1);
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({do_wr, do_rd})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;
  assign empty_o   = (cnt_q == '0);

endmodule

// File: rtl/sram_frame_reader.sv
// Streams one frame of RGB565 pixels from the board SRAM in raster order,
// expands them to RGB888 and hands them to the VGA controller on demand.
// Ports:
//   clk, rst_n             50 MHz clock, asynchronous active-low reset
//   frame_start            vsync pulse: flush and restart fetching at BASE_ADDR
//   pix_req                pop one pixel; answer appears on the next cycle
//   pix_rgb, pix_valid     registered {R8,G8,B8} and its valid flag
//   underflow              sticky: a request found the FIFO empty
//   SRAM_*                 read-only asynchronous SRAM port
module sram_frame_reader
  import vga_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR  = 20'h00000,
  parameter int          H_ACTIVE   = H_ACTIVE_DEF,
  parameter int          V_ACTIVE   = V_ACTIVE_DEF,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_req,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  output logic        underflow,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TOTAL = 32'(H_ACTIVE * V_ACTIVE);
  localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

  rd_state_e   state_q, state_d;
  logic [19:0] rd_addr_q, rd_addr_d;     // next address to issue
  logic [31:0] issued_q, issued_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic        vld_p0_q, vld_p1_q;
  logic [15:0] dq_p1_q;
  logic [23:0] pix_rgb_q, pix_rgb_d;
  logic        pix_valid_q, pix_valid_d;
  logic        underflow_q, underflow_d;

  logic          issue, fetching, room;
  logic [19:0]   cur_addr;
  logic [31:0]   cur_cnt;
  logic [CW:0]   pending;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_wr, fifo_pop;
  logic [23:0]   fifo_rd_data;

  // Occupancy plus reads still travelling through the pipeline; issuing only
  // while this is below the depth means every issued read has a slot.
  assign pending = {1'b0, fifo_count} + (CW+1)'(vld_p0_q) + (CW+1)'(vld_p1_q);
  assign room    = (pending < LIMIT);

  // frame_start both restarts the frame and issues its first read in the
  // same cycle; the flush guarantees room for it.
  always_comb begin
    state_d     = state_q;
    sram_addr_d = sram_addr_q;
    fetching    = frame_start || (state_q == ST_FETCH);
    cur_addr    = frame_start ? BASE_ADDR : rd_addr_q;
    cur_cnt     = frame_start ? 32'd0 : issued_q;
    issue       = fetching && (cur_cnt < TOTAL) && (frame_start || room);
    rd_addr_d   = cur_addr;
    issued_d    = cur_cnt;
    if (issue) begin
      sram_addr_d = cur_addr;
      rd_addr_d   = cur_addr + 20'd1;
      issued_d    = cur_cnt + 32'd1;
    end
    if (fetching) begin
      state_d = (issued_d == TOTAL) ? ST_DONE : ST_FETCH;
    end
  end

  assign fifo_pop = pix_req && !frame_start && !fifo_empty;
  assign fifo_wr  = vld_p1_q && !frame_start;

  always_comb begin
    pix_valid_d = fifo_pop;
    pix_rgb_d   = fifo_pop ? fifo_rd_data : 24'h000000;
    underflow_d = underflow_q;
    if (frame_start) begin
      underflow_d = 1'b0;
    end else if (pix_req && fifo_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= BASE_ADDR;
      issued_q    <= '0;
      sram_addr_q <= BASE_ADDR;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      issued_q    <= issued_d;
      // p0: address on the SRAM bus with OE asserted
      sram_addr_q <= sram_addr_d;
      vld_p0_q    <= issue;
      // p1: SRAM data captured; in-flight reads die on frame_start
      vld_p1_q    <= vld_p0_q && !frame_start;
      // output stage: popped pixel
      pix_rgb_q   <= pix_rgb_d;
      pix_valid_q <= pix_valid_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    dq_p1_q <= SRAM_DQ;
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (24)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (frame_start),
    .wr_en_i   (fifo_wr),
    .wr_data_i (rgb565_to_888(dq_p1_q)),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  assign SRAM_DQ   = 16'hzzzz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_OE_N = ~vld_p0_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_WE_N = 1'b1;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;

  assign pix_rgb   = pix_rgb_q;
  assign pix_valid = pix_valid_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader on a small 8x4 frame with a 16-deep
// FIFO. SRAM word k holds k[15:0], except word 0 which holds 16'hF800.
module tb_sram_frame_reader;
  import vga_pkg::*;

  localparam int H = 8;
  localparam int V = 4;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_req = 1'b0;
  logic [23:0] pix_rgb;
  logic        pix_valid, underflow;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  int total = 0;
  int bad = 0;
  int unsigned rd_cnt = 0;
  int unsigned rd_base;

  always #10 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    return (a == 20'd0) ? 16'hF800 : a[15:0];
  endfunction

  assign sram_dq = oe_n ? 16'hzzzz : mem_word(sram_addr);

  always @(posedge clk) if (!oe_n) rd_cnt <= rd_cnt + 1;

  sram_frame_reader #(
    .BASE_ADDR  (20'h00000),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_rgb     (pix_rgb),
    .pix_valid   (pix_valid),
    .underflow   (underflow),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DQ     (sram_dq),
    .SRAM_CE_N   (ce_n),
    .SRAM_OE_N   (oe_n),
    .SRAM_WE_N   (we_n),
    .SRAM_LB_N   (lb_n),
    .SRAM_UB_N   (ub_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected pixel for raster index idx, written out from the 565->888 rule.
  function automatic logic [23:0] exp_pix(input int idx);
    logic [15:0] d;
    d = (idx == 0) ? 16'hF800 : 16'(idx);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pop_one();
    pix_req = 1'b1;
    @(negedge clk);
    pix_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and static SRAM controls
    cycles(2);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_rgb", 32'(pix_rgb), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("ctl_we_ce_lb_ub", {28'd0, we_n, ce_n, lb_n, ub_n}, 32'b1000);
    rst_n = 1'b1;
    cycles(4);
    chk("idle_no_read", 32'(oe_n), 32'd1);

    // Frame start, then an immediate request against the empty FIFO
    rd_base = rd_cnt;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("first_read_addr", 32'(sram_addr), 32'd0);
    chk("first_read_oe", 32'(oe_n), 32'd0);
    pop_one();
    chk("empty_pop_valid", 32'(pix_valid), 32'd0);
    chk("empty_pop_rgb", 32'(pix_rgb), 32'd0);
    chk("empty_pop_underflow", 32'(underflow), 32'd1);
    chk("second_read_addr", 32'(sram_addr), 32'd1);

    // FIFO fills to 16 and reads stop
    cycles(30);
    chk("fill_reads", rd_cnt - rd_base, 32'd16);
    chk("fill_oe_off", 32'(oe_n), 32'd1);
    chk("fill_last_addr", 32'(sram_addr), 32'd15);
    chk("underflow_sticky", 32'(underflow), 32'd1);

    // Pops of red (F800) and word 1
    pop_one();
    chk("pop0_valid", 32'(pix_valid), 32'd1);
    chk("pop0_rgb", 32'(pix_rgb), 32'hFF0000);
    pop_one();
    chk("pop1_rgb", 32'(pix_rgb), 32'h000008);
    cycles(10);
    chk("refill_reads", rd_cnt - rd_base, 32'd18);
    chk("refill_addr", 32'(sram_addr), 32'd17);

    // frame_start with pix_req in the same cycle
    rd_base = rd_cnt;
    frame_start = 1'b1;
    pix_req = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    pix_req = 1'b0;
    chk("fs_req_valid", 32'(pix_valid), 32'd0);
    chk("fs_req_rgb", 32'(pix_rgb), 32'd0);
    chk("fs_clears_underflow", 32'(underflow), 32'd0);
    chk("fs_restart_addr", 32'(sram_addr), 32'd0);
    chk("fs_restart_oe", 32'(oe_n), 32'd0);
    cycles(20);
    chk("restart_reads", rd_cnt - rd_base, 32'd16);
    pop_one();
    chk("flushed_first_rgb", 32'(pix_rgb), 32'hFF0000);

    // Whole frame, one request every two cycles
    rd_base = rd_cnt;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cycles(5);
    for (int i = 0; i < NPIX; i++) begin
      pop_one();
      chk($sformatf("stream_valid_%0d", i), 32'(pix_valid), 32'd1);
      chk($sformatf("stream_rgb_%0d", i), 32'(pix_rgb), 32'(exp_pix(i)));
      @(negedge clk);
    end
    cycles(5);
    chk("frame_underflow", 32'(underflow), 32'd0);
    chk("frame_state_done", {30'd0, dut.state_q}, {30'd0, ST_DONE});
    chk("frame_last_addr", 32'(sram_addr), 32'(NPIX - 1));
    chk("frame_reads", rd_cnt - rd_base, 32'(NPIX));
    chk("frame_oe_off", 32'(oe_n), 32'd1);
    pop_one();
    chk("done_empty_valid", 32'(pix_valid), 32'd0);
    chk("done_empty_rgb", 32'(pix_rgb), 32'd0);
    chk("done_empty_underflow", 32'(underflow), 32'd1);

    // Reset in the middle of fetching
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cycles(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", 32'(oe_n), 32'd1);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    chk("midrst_valid", 32'(pix_valid), 32'd0);
    chk("midrst_rgb", 32'(pix_rgb), 32'd0);
    chk("midrst_underflow", 32'(underflow), 32'd0);
    chk("midrst_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    rd_base = rd_cnt;
    cycles(10);
    chk("postrst_reads", rd_cnt - rd_base, 32'd0);
    chk("postrst_oe", 32'(oe_n), 32'd1);
    pop_one();
    chk("postrst_fifo_empty", 32'(pix_valid), 32'd0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("postrst_restart_addr", 32'(sram_addr), 32'd0);
    chk("postrst_restart_oe", 32'(oe_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
